// File: rtl/streamif_cmd_sched.sv
// streamif_cmd_sched: in-order StreamIF endpoint command scheduler; define STREAMIF_SCHED_TIMEOUT_EN for a 256-cycle ACK timeout
module streamif_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int EP_COUNT = 16
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        CMD_Valid,
  output logic        CMD_Ready,
  input  logic [31:0] CMD_Addr,
  input  logic [3:0]  CMD_Ep,
  output logic [31:0] StreamIF_CTRL_Addr,
  output logic [15:0] StreamIF_CTRL_AddrValid,
  output logic [15:0] StreamIF_CTRL_Start,
  input  logic [15:0] StreamIF_CTRL_Idle,
  output logic [15:0] Busy,
  output logic        DONE_Valid,
  output logic [3:0]  DONE_Ep,
  output logic        DONE_Err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] EP_LIM = 5'(EP_COUNT);
  typedef enum logic [1:0] {IDLE, LOAD, START, ACK} state_t;
  state_t state_q, state_d;
  logic [23:0] mem_q [FIFO_DEPTH];
  logic [23:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0] ep_q, ep_d, dep_q, dep_d, rep_idx;
  logic [15:0] busy_q, busy_d, pend_q, pend_d, err_q, err_d;
  logic dv_q, dv_d, derr_q, derr_d;
  logic [15:0] set_busy, clr_busy, set_pend, set_err, cmp, rep;
  logic [23:0] head;
  logic push, pop, bad, unused_ok;
`ifdef STREAMIF_SCHED_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
`endif
  assign head = mem_q[rd_q];
  assign bad = {1'b0, head[3:0]} >= EP_LIM;
  assign CMD_Ready = ~cnt_q[AW];
  assign push = CMD_Valid & CMD_Ready;
  assign unused_ok = ^CMD_Addr[11:0];
  assign StreamIF_CTRL_Addr = {addr_q, 12'h000};
  assign StreamIF_CTRL_AddrValid = (state_q == LOAD) ? 16'd1 << ep_q : '0;
  assign StreamIF_CTRL_Start = (state_q == START) ? 16'd1 << ep_q : '0;
  assign Busy = busy_q;
  assign DONE_Valid = dv_q;
  assign DONE_Ep = dep_q;
  assign DONE_Err = derr_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {CMD_Addr[31:12], CMD_Ep};
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    ep_d = ep_q;
    pop = 1'b0;
    set_busy = '0;
    clr_busy = '0;
    set_pend = '0;
    set_err = '0;
`ifdef STREAMIF_SCHED_TIMEOUT_EN
    tmo_d = tmo_q;
`endif
    case (state_q)
      IDLE: if (cnt_q != '0) begin
        if (bad) begin
          pop = 1'b1;
          set_pend = 16'd1 << head[3:0];
          set_err = set_pend;
        end else if (!busy_q[head[3:0]]) begin
          addr_d = head[23:4];
          ep_d = head[3:0];
          state_d = LOAD;
        end
      end
      LOAD: state_d = START;
      START: begin
        pop = 1'b1;
        set_busy = 16'd1 << ep_q;
        state_d = ACK;
`ifdef STREAMIF_SCHED_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      ACK: if (!StreamIF_CTRL_Idle[ep_q]) state_d = IDLE;
`ifdef STREAMIF_SCHED_TIMEOUT_EN
      else if (tmo_q == 8'hff) begin
        clr_busy = 16'd1 << ep_q;
        set_pend = clr_busy;
        set_err = clr_busy;
        state_d = IDLE;
      end else tmo_d = tmo_q + 8'd1;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cmp = busy_q & StreamIF_CTRL_Idle & ((state_q == ACK) ? ~(16'd1 << ep_q) : '1);
    rep_idx = '0;
    for (int i = 15; i >= 0; i--) if (pend_q[i]) rep_idx = 4'(i);
    rep = (|pend_q) ? 16'd1 << rep_idx : '0;
    busy_d = (busy_q | set_busy) & ~cmp & ~clr_busy;
    pend_d = (pend_q & ~rep) | cmp | set_pend;
    err_d = (err_q & ~rep & ~cmp) | set_err;
    dv_d = |pend_q;
    dep_d = rep_idx;
    derr_d = err_q[rep_idx];
  end
  always_ff @(posedge ACLK) mem_q <= mem_d;
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      ep_q <= '0;
      busy_q <= '0;
      pend_q <= '0;
      err_q <= '0;
      dv_q <= 1'b0;
      dep_q <= '0;
      derr_q <= 1'b0;
`ifdef STREAMIF_SCHED_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      ep_q <= ep_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
      err_q <= err_d;
      dv_q <= dv_d;
      dep_q <= dep_d;
      derr_q <= derr_d;
`ifdef STREAMIF_SCHED_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_streamif_cmd_sched.sv
// tb_streamif_cmd_sched: directed-vector bench for streamif_cmd_sched (FIFO_DEPTH=4, EP_COUNT=8)
module tb_streamif_cmd_sched;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic CMD_Valid = 1'b0;
  logic CMD_Ready;
  logic [31:0] CMD_Addr = '0;
  logic [3:0] CMD_Ep = '0;
  logic [31:0] ctrl_addr;
  logic [15:0] ctrl_av, ctrl_start, busy;
  logic [15:0] idle = '1;
  logic done_valid, done_err;
  logic [3:0] done_ep;
  int n_vec = 0;
  int n_err = 0;
  int cyc;
  logic [31:0] q_addr [4] = '{32'hB000_1000, 32'hC000_2000, 32'hD000_3000, 32'hE000_4000};
  logic [3:0] q_ep [4] = '{4'd1, 4'd2, 4'd1, 4'd1};
  always #5 ACLK = ~ACLK;
  streamif_cmd_sched #(.FIFO_DEPTH(4), .EP_COUNT(8)) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .CMD_Valid(CMD_Valid),
    .CMD_Ready(CMD_Ready),
    .CMD_Addr(CMD_Addr),
    .CMD_Ep(CMD_Ep),
    .StreamIF_CTRL_Addr(ctrl_addr),
    .StreamIF_CTRL_AddrValid(ctrl_av),
    .StreamIF_CTRL_Start(ctrl_start),
    .StreamIF_CTRL_Idle(idle),
    .Busy(busy),
    .DONE_Valid(done_valid),
    .DONE_Ep(done_ep),
    .DONE_Err(done_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge ACLK);
    #1;
  endtask
  task automatic cmd(input logic [31:0] a, input logic [3:0] e);
    CMD_Valid = 1'b1;
    CMD_Addr = a;
    CMD_Ep = e;
  endtask
  initial begin
    tick(3);
    chk("rst_ready", 32'(CMD_Ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({done_valid, done_ep, done_err}), 32'd0);
    chk("rst_ctrl", {ctrl_av, ctrl_start}, 32'd0);
    chk("rst_addr", ctrl_addr, 32'd0);
    ARESETN = 1'b1;
    cmd(32'h1234_5ABC, 4'd3);
    tick;
    CMD_Valid = 1'b0;
    chk("t1_av_early", 32'(ctrl_av), 32'd0);
    tick;
    chk("t1_av", 32'(ctrl_av), 32'h0008);
    chk("t1_addr", ctrl_addr, 32'h1234_5000);
    chk("t1_start_early", 32'(ctrl_start), 32'd0);
    tick;
    chk("t1_start", 32'(ctrl_start), 32'h0008);
    chk("t1_av_once", 32'(ctrl_av), 32'd0);
    tick;
    chk("t1_busy", 32'(busy), 32'h0008);
    chk("t1_start_once", 32'(ctrl_start), 32'd0);
    tick;
    idle[3] = 1'b0;
    tick(10);
    idle[3] = 1'b1;
    chk("t1_busy_hold", 32'(busy), 32'h0008);
    chk("t1_addr_hold", ctrl_addr, 32'h1234_5000);
    tick;
    chk("t1_busy_clr", 32'(busy), 32'd0);
    chk("t1_done_early", 32'(done_valid), 32'd0);
    tick;
    chk("t1_done", 32'({done_valid, done_ep, done_err}), 32'({1'b1, 4'd3, 1'b0}));
    tick;
    chk("t1_done_once", 32'(done_valid), 32'd0);
    cmd(32'hDEAD_B000, 4'd12);
    tick;
    CMD_Valid = 1'b0;
    chk("bad_ctrl_c1", {ctrl_av, ctrl_start}, 32'd0);
    tick;
    chk("bad_ctrl_c2", {ctrl_av, ctrl_start}, 32'd0);
    chk("bad_done_early", 32'(done_valid), 32'd0);
    tick;
    chk("bad_done", 32'({done_valid, done_ep, done_err}), 32'({1'b1, 4'd12, 1'b1}));
    chk("bad_ctrl_c3", {ctrl_av, ctrl_start}, 32'd0);
    chk("bad_busy", 32'(busy), 32'd0);
    tick;
    chk("bad_done_once", 32'(done_valid), 32'd0);
    cmd(32'h5000_0000, 4'd5);
    tick;
    cmd(32'h2000_0000, 4'd2);
    tick;
    CMD_Valid = 1'b0;
    tick(2);
    chk("sim_busy5", 32'(busy), 32'h0020);
    idle[5] = 1'b0;
    tick(2);
    chk("sim_av2", 32'(ctrl_av), 32'h0004);
    chk("sim_addr2", ctrl_addr, 32'h2000_0000);
    tick(2);
    idle[2] = 1'b0;
    tick(2);
    chk("sim_busy", 32'(busy), 32'h0024);
    idle[2] = 1'b1;
    idle[5] = 1'b1;
    tick;
    chk("sim_busy_clr", 32'(busy), 32'd0);
    chk("sim_done_early", 32'(done_valid), 32'd0);
    tick;
    chk("sim_done_2", 32'({done_valid, done_ep, done_err}), 32'({1'b1, 4'd2, 1'b0}));
    tick;
    chk("sim_done_5", 32'({done_valid, done_ep, done_err}), 32'({1'b1, 4'd5, 1'b0}));
    tick;
    chk("sim_done_end", 32'(done_valid), 32'd0);
    cmd(32'hA000_0000, 4'd1);
    tick;
    CMD_Valid = 1'b0;
    tick(3);
    idle[1] = 1'b0;
    tick;
    chk("ord_busy1", 32'(busy), 32'h0002);
    for (int i = 0; i < 4; i++) begin
      cmd(q_addr[i], q_ep[i]);
      chk("ord_ready", 32'(CMD_Ready), 32'd1);
      tick;
    end
    cmd(32'hF000_5000, 4'd3);
    for (int i = 0; i < 3; i++) begin
      chk("full_ready", 32'(CMD_Ready), 32'd0);
      chk("blocked_ctrl", {ctrl_av, ctrl_start}, 32'd0);
      tick;
    end
    chk("full_ready_r", 32'(CMD_Ready), 32'd0);
    idle[1] = 1'b1;
    tick;
    chk("ord_busy_clr", 32'(busy), 32'd0);
    chk("ord_av_wait", 32'(ctrl_av), 32'd0);
    tick;
    chk("ord_av_b", 32'(ctrl_av), 32'h0002);
    chk("ord_addr_b", ctrl_addr, 32'hB000_1000);
    chk("ord_done_a", 32'({done_valid, done_ep, done_err}), 32'({1'b1, 4'd1, 1'b0}));
    chk("full_ready_r2", 32'(CMD_Ready), 32'd0);
    tick;
    chk("ord_start_b", 32'(ctrl_start), 32'h0002);
    chk("full_ready_r3", 32'(CMD_Ready), 32'd0);
    tick;
    chk("full_ready_pop", 32'(CMD_Ready), 32'd1);
    chk("ord_busy_b", 32'(busy), 32'h0002);
    idle[1] = 1'b0;
    tick;
    CMD_Valid = 1'b0;
    chk("full_ready_5th", 32'(CMD_Ready), 32'd0);
    tick;
    chk("ord_av_c", 32'(ctrl_av), 32'h0004);
    chk("ord_addr_c", ctrl_addr, 32'hC000_2000);
    tick;
    chk("ord_start_c", 32'(ctrl_start), 32'h0004);
    tick;
    chk("ack_busy", 32'(busy), 32'h0006);
    ARESETN = 1'b0;
    tick;
    chk("mid_rst_ready", 32'(CMD_Ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ctrl", {ctrl_av, ctrl_start}, 32'd0);
    chk("mid_rst_addr", ctrl_addr, 32'd0);
    chk("mid_rst_done", 32'({done_valid, done_ep, done_err}), 32'd0);
    ARESETN = 1'b1;
    idle = '1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_done", 32'(done_valid), 32'd0);
      chk("post_rst_av", 32'(ctrl_av), 32'd0);
      chk("post_rst_ready", 32'(CMD_Ready), 32'd1);
    end
    cmd(32'h4000_0000, 4'd4);
    tick;
    CMD_Valid = 1'b0;
    cyc = 1;
    while (!done_valid && cyc < 400) begin
      tick;
      cyc++;
    end
`ifdef STREAMIF_SCHED_TIMEOUT_EN
    chk("tmo_cycle", 32'(cyc), 32'd261);
    chk("tmo_done", 32'({done_valid, done_ep, done_err}), 32'({1'b1, 4'd4, 1'b1}));
    chk("tmo_busy", 32'(busy), 32'd0);
`else
    chk("stuck_no_done", 32'(done_valid), 32'd0);
    chk("stuck_busy", 32'(busy), 32'h0010);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/streamif_cmd_sched.md
# streamif_cmd_sched

Hardware command scheduler for the StreamIF endpoint control bus. Accepts transfer commands (page address plus endpoint index) through a small in-order FIFO, programs the addressed endpoint over the shared Addr/AddrValid/Start bus, and tracks each endpoint's busy state from its Idle line. Reports completions one per cycle. Sits between a command source (AXI-lite register front end or a hardware thread) and up to 16 StreamIF read/write endpoints: endpoint 2k is the read side and 2k+1 the write side of HWT k.

## Interface
- FIFO_DEPTH, 4: command FIFO entries; power of two, 2..16.
- EP_COUNT, 16: implemented endpoints; even, 2..16. Bits at EP_COUNT and above are unused.
- ACLK  in  1  clock.
- ARESETN  in  1  reset. One clock; reset is synchronous and active-low.
- CMD_Valid  in  1  command offered.
- CMD_Ready  out  1  FIFO not full; a command transfers when Valid&Ready.
- CMD_Addr  in  32  buffer address; bits [11:0] ignored.
- CMD_Ep  in  4  target endpoint index.
- StreamIF_CTRL_Addr  out  32  shared page address {addr[31:12],12'b0}.
- StreamIF_CTRL_AddrValid  out  16  one-hot address strobe.
- StreamIF_CTRL_Start  out  16  one-hot start pulse.
- StreamIF_CTRL_Idle  in  16  endpoint idle status.
- Busy  out  16  endpoint has a transfer in flight.
- DONE_Valid  out  1  one-cycle completion report.
- DONE_Ep  out  4  completed endpoint index.
- DONE_Err  out  1  report is an error: bad index or timeout.

## Operation
- FIFO: FIFO_DEPTH entries of {addr[31:12], ep}, in order. CMD_Ready = count < FIFO_DEPTH. Push and pop in the same cycle are allowed.
- FSM states: IDLE, LOAD, START, ACK.
- IDLE
  - If the FIFO is non-empty and head ep >= EP_COUNT: pop the entry, raise done_pend[ep] and err_pend[ep] for reporting, stay in IDLE.
  - If the FIFO is non-empty and Busy[head ep]=0: latch addr and ep, go to LOAD.
  - If the head endpoint is busy, wait. Head-of-line blocking is intentional and preserves order.
- LOAD: AddrValid[ep]=1 for exactly one cycle; Addr driven from the latch; go to START.
- START: Start[ep]=1 for one cycle; pop the FIFO; set Busy[ep]; clear the ack counter; go to ACK.
- ACK: wait for Idle[ep]=0, then go to IDLE. Only one endpoint is awaiting acknowledge at a time.
- Completion: Busy[i] clears when Busy[i]&Idle[i] and endpoint i is not the one in ACK. The same cycle sets done_pend[i].
- Reporting: each cycle the lowest-index set done_pend bit is output as DONE_Valid/DONE_Ep/DONE_Err (registered) and that bit is cleared. No backpressure. A bit set and reported in the same cycle is impossible because the set takes effect next cycle.
- StreamIF_CTRL_Addr holds its last value outside LOAD/START.

## Timing
- Reset values: all outputs 0 except CMD_Ready=1; FIFO empty; Busy, done_pend, err_pend cleared; FSM in IDLE.
- Reset mid-operation: all in-flight state is discarded and no completions are reported.
- Command accepted in cycle t is at the FIFO head in t+1. With its endpoint free: IDLE in t+1, AddrValid in t+2, Start in t+3, ACK from t+4.
- Earliest next Start: 4 cycles after the previous Start (ACK 1 cycle, IDLE, LOAD, START).
- Idle rising in cycle c with Busy set: Busy=0 and done_pend set in c+1; DONE_Valid in c+2 if no lower index is pending.
- Simultaneous completions: reported on consecutive cycles, ascending index.
- Full FIFO: CMD_Ready=0. A pop in cycle t raises CMD_Ready in t+1.

## Configuration
- STREAMIF_SCHED_TIMEOUT_EN
  - Defined: an 8-bit counter runs in ACK. If Idle[ep] stays high for 256 cycles, Busy[ep] is cleared, done_pend[ep] and err_pend[ep] are set, and the FSM returns to IDLE.
  - Undefined: ACK waits indefinitely and DONE_Err is raised only for a bad index.

## Test plan
- Single command (Addr=0x1234_5ABC, Ep=3), Idle[3] drops 2 cycles after Start and rises 10 cycles later -> Addr=0x1234_5000; AddrValid=0x0008 one cycle, then Start=0x0008 one cycle; Busy[3] during the transfer; DONE_Valid, Ep=3, Err=0 two cycles after the Idle rise.
- Push 5 commands with FIFO_DEPTH=4, no dispatch possible -> CMD_Ready low after 4 accepted; 5th accepted one cycle after the first pop.
- Two commands to Ep=1, back-to-back -> second Start only after Busy[1] clears; Ep=2 command queued behind them waits too (in-order).
- Endpoints 5 and 2 complete in the same cycle -> DONE_Ep=2 then DONE_Ep=5 on consecutive cycles.
- Ep=12 with EP_COUNT=8 -> no AddrValid/Start; DONE_Valid with Ep=12, Err=1. With timeout enabled, Idle held high -> DONE_Err=1 after 256 ACK cycles.
- ARESETN low for 1 cycle during ACK -> all outputs return to reset values, no DONE_Valid, FIFO empty.
